// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions used by the scanout reader and its output FIFO.
package fb_pkg;
  localparam int H_RES     = 800;
  localparam int V_RES     = 480;
  localparam int FB_PIXELS = H_RES * V_RES;
  localparam int FB_ADDRW  = $clog2(FB_PIXELS);
  localparam int PIXW      = 4;

  localparam logic [PIXW-1:0] BG_INDEX          = 4'h0;
  localparam logic [PIXW-1:0] TRANSPARENT_INDEX = 4'hF;

  typedef struct packed {
    logic [PIXW-1:0] pix;
    logic            sol;
    logic            eof;
  } fb_beat_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN
  } scan_state_t;
endpackage

// File: rtl/fb_fifo.sv
// First-word-fall-through FIFO of scanout beats with an occupancy count.
module fb_fifo
  import fb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  fb_beat_t      din,
  input  logic          pop,
  output fb_beat_t      dout,
  output logic          empty,
  output logic [AW:0]   count
);
  fb_beat_t      mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is data only; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);
endmodule

// File: rtl/fb_scanout.sv
// Raster-order frame-buffer reader with credit-limited read pipeline,
// ready/valid pixel output and optional clear-behind writes.
module fb_scanout
  import fb_pkg::*;
#(
  parameter int               H_RES      = fb_pkg::H_RES,
  parameter int               V_RES      = fb_pkg::V_RES,
  parameter int               PIXW       = fb_pkg::PIXW,
  parameter int               ADDRW      = fb_pkg::FB_ADDRW,
  parameter bit               HALF_RES   = 1'b0,
  parameter int               RD_LAT     = 1,
  parameter int               FIFO_DEPTH = 4,
  parameter bit               CLEAR_EN   = 1'b1,
  parameter logic [PIXW-1:0]  BG_INDEX   = fb_pkg::BG_INDEX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fb_rd_en,
  output logic [ADDRW-1:0]  fb_rd_addr,
  input  logic [PIXW-1:0]   fb_rd_data,
  output logic              fb_wr_en,
  output logic [ADDRW-1:0]  fb_wr_addr,
  output logic [PIXW-1:0]   fb_wr_data,
  output logic [PIXW-1:0]   pix,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sol,
  output logic              pix_eof
);
  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [XW-1:0]    X_LAST    = XW'(H_RES - 1);
  localparam logic [YW-1:0]    Y_LAST    = YW'(V_RES - 1);
  localparam logic [ADDRW-1:0] LINE_STEP = ADDRW'(H_RES);

  typedef struct packed {
    logic [ADDRW-1:0] addr;
    logic             sol;
    logic             eof;
    logic             xodd;
  } rd_tag_t;

  scan_state_t      state;
  scan_state_t      state_nxt;
  logic [XW-1:0]    x;
  logic [YW-1:0]    y;
  logic [ADDRW-1:0] line_base;
  logic [ADDRW-1:0] pix_addr;
  logic             last_pix;
  logic             rd_issue;
  logic             vld_p [RD_LAT];
  rd_tag_t          tag_p [RD_LAT];
  logic             tap_vld;
  rd_tag_t          tap_tag;
  logic [CW-1:0]    occupancy;
  logic [CW-1:0]    inflight;
  fb_beat_t         push_beat;
  fb_beat_t         head;
  logic             fifo_empty;
  logic             pop;

  assign pix_addr   = line_base + ADDRW'(x);
  assign last_pix   = (x == X_LAST) && (y == Y_LAST);
  assign fb_rd_addr = HALF_RES ? (pix_addr >> 1) : pix_addr;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CW'(vld_p[i]);
  end

  // Credit counts both queued beats and reads still in the memory pipe,
  // so every returning word is guaranteed a FIFO slot.
  assign rd_issue = (state == ST_READ) && !rst &&
                    ((int'(occupancy) + int'(inflight)) < FIFO_DEPTH);
  assign fb_rd_en = rd_issue;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_READ;
      end
      ST_READ: begin
        busy = 1'b1;
        if (rd_issue && last_pix) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (pop && head.eof) begin
          state_nxt = ST_IDLE;
          done      = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x         <= '0;
      y         <= '0;
      line_base <= '0;
    end else if (rd_issue) begin
      if (x == X_LAST) begin
        x <= '0;
        if (y == Y_LAST) begin
          y         <= '0;
          line_base <= '0;
        end else begin
          y         <= y + 1'b1;
          line_base <= line_base + LINE_STEP;
        end
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  // Read pipe stage 0..RD_LAT-1: valid and tags track the memory latency
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= rd_issue;
      for (int i = 1; i < RD_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    tag_p[0] <= '{addr: fb_rd_addr, sol: (x == '0), eof: last_pix, xodd: x[0]};
    for (int i = 1; i < RD_LAT; i++) tag_p[i] <= tag_p[i-1];
  end

  assign tap_vld   = vld_p[RD_LAT-1];
  assign tap_tag   = tag_p[RD_LAT-1];
  assign push_beat = '{pix: fb_rd_data, sol: tap_tag.sol, eof: tap_tag.eof};

  // Capture stage: returning word enters the FIFO, location is cleared behind
  fb_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tap_vld),
    .din   (push_beat),
    .pop   (pop),
    .dout  (head),
    .empty (fifo_empty),
    .count (occupancy)
  );

  // A pixel pair shares one word in half-res mode; clear it after the odd pixel.
  assign fb_wr_en   = CLEAR_EN && tap_vld && !rst && (!HALF_RES || tap_tag.xodd);
  assign fb_wr_addr = fb_wr_en ? tap_tag.addr : '0;
  assign fb_wr_data = BG_INDEX;

  assign pix_valid = !fifo_empty;
  assign pop       = pix_valid && pix_ready;
  assign pix       = pix_valid ? head.pix : '0;
  assign pix_sol   = pix_valid && head.sol;
  assign pix_eof   = pix_valid && head.eof;
endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench: three 8x2 scanout instances (RD_LAT=1, RD_LAT=2, half-res)
// each paired with a small frame-buffer memory model.
module tb_fb_scanout;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic load;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- instance 0: RD_LAT=1, full res, clear-behind
  logic        start0, busy0, done0, rd_en0, wr_en0, vld0, rdy0, sol0, eof0;
  logic [18:0] rd_addr0, wr_addr0;
  logic [3:0]  rd_data0, wr_data0, pix0;
  logic [3:0]  mem0 [16];

  fb_scanout #(.H_RES(8), .V_RES(2), .HALF_RES(1'b0), .RD_LAT(1), .FIFO_DEPTH(4),
               .CLEAR_EN(1'b1), .BG_INDEX(4'h0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
    .fb_rd_en(rd_en0), .fb_rd_addr(rd_addr0), .fb_rd_data(rd_data0),
    .fb_wr_en(wr_en0), .fb_wr_addr(wr_addr0), .fb_wr_data(wr_data0),
    .pix(pix0), .pix_valid(vld0), .pix_ready(rdy0), .pix_sol(sol0), .pix_eof(eof0));

  always @(posedge clk) begin
    if (rd_en0) rd_data0 <= mem0[rd_addr0[3:0]];
    if (load) for (int i = 0; i < 16; i++) mem0[i] <= 4'(i);
    else if (wr_en0) mem0[wr_addr0[3:0]] <= wr_data0;
  end

  logic [5:0] acc0_q[$];
  int         acc0_cyc[$];
  int         wr0_q[$];
  int         done0_q[$];
  always @(negedge clk) begin
    if (vld0 && rdy0) begin acc0_q.push_back({pix0, sol0, eof0}); acc0_cyc.push_back(cyc); end
    if (wr_en0) wr0_q.push_back(int'(wr_addr0));
    if (done0) done0_q.push_back(cyc);
  end

  // ---------------- instance 1: RD_LAT=2, full res, random back-pressure
  logic        start1, busy1, done1, rd_en1, wr_en1, vld1, rdy1, sol1, eof1;
  logic [18:0] rd_addr1, wr_addr1;
  logic [3:0]  rd_data1, rd_stage1, wr_data1, pix1;
  logic [3:0]  mem1 [16];

  fb_scanout #(.H_RES(8), .V_RES(2), .HALF_RES(1'b0), .RD_LAT(2), .FIFO_DEPTH(4),
               .CLEAR_EN(1'b1), .BG_INDEX(4'h0)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .fb_rd_en(rd_en1), .fb_rd_addr(rd_addr1), .fb_rd_data(rd_data1),
    .fb_wr_en(wr_en1), .fb_wr_addr(wr_addr1), .fb_wr_data(wr_data1),
    .pix(pix1), .pix_valid(vld1), .pix_ready(rdy1), .pix_sol(sol1), .pix_eof(eof1));

  always @(posedge clk) begin
    if (rd_en1) rd_stage1 <= mem1[rd_addr1[3:0]];
    rd_data1 <= rd_stage1;
    if (load) for (int i = 0; i < 16; i++) mem1[i] <= 4'(i);
    else if (wr_en1) mem1[wr_addr1[3:0]] <= wr_data1;
  end

  logic [5:0] acc1_q[$];
  int         wr1_q[$];
  int         done1_q[$];
  int         iss1 = 0, pop1 = 0, max_out1 = 0, unstable1 = 0;
  logic       hold1 = 1'b0;
  logic [5:0] held1;
  always @(negedge clk) begin
    if (hold1 && (vld1 !== 1'b1 || {pix1, sol1, eof1} !== held1)) unstable1++;
    hold1 = vld1 && !rdy1;
    held1 = {pix1, sol1, eof1};
    if (rd_en1) iss1++;
    if (iss1 - pop1 > max_out1) max_out1 = iss1 - pop1;
    if (vld1 && rdy1) begin acc1_q.push_back({pix1, sol1, eof1}); pop1++; end
    if (wr_en1) wr1_q.push_back(int'(wr_addr1));
    if (done1) done1_q.push_back(cyc);
  end

  // ---------------- instance 2: RD_LAT=1, half res
  logic        start2, busy2, done2, rd_en2, wr_en2, vld2, rdy2, sol2, eof2;
  logic [18:0] rd_addr2, wr_addr2;
  logic [3:0]  rd_data2, wr_data2, pix2;
  logic [3:0]  mem2 [16];

  fb_scanout #(.H_RES(8), .V_RES(2), .HALF_RES(1'b1), .RD_LAT(1), .FIFO_DEPTH(4),
               .CLEAR_EN(1'b1), .BG_INDEX(4'h0)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
    .fb_rd_en(rd_en2), .fb_rd_addr(rd_addr2), .fb_rd_data(rd_data2),
    .fb_wr_en(wr_en2), .fb_wr_addr(wr_addr2), .fb_wr_data(wr_data2),
    .pix(pix2), .pix_valid(vld2), .pix_ready(rdy2), .pix_sol(sol2), .pix_eof(eof2));

  always @(posedge clk) begin
    if (rd_en2) rd_data2 <= mem2[rd_addr2[3:0]];
    if (load) for (int i = 0; i < 16; i++) mem2[i] <= 4'(i);
    else if (wr_en2) mem2[wr_addr2[3:0]] <= wr_data2;
  end

  logic [5:0] acc2_q[$];
  int         rd2_q[$];
  int         wr2_q[$];
  int         done2_q[$];
  always @(negedge clk) begin
    if (vld2 && rdy2) acc2_q.push_back({pix2, sol2, eof2});
    if (rd_en2) rd2_q.push_back(int'(rd_addr2));
    if (wr_en2) wr2_q.push_back(int'(wr_addr2));
    if (done2) done2_q.push_back(cyc);
  end

  // ---------------- directed sequence
  int         a, b, w, d, r;
  logic [5:0] exp_beat, got_beat;
  logic [3:0] orv;

  initial begin
    rst = 1'b1; load = 1'b0;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    rdy0 = 1'b1; rdy1 = 1'b1; rdy2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_rd_en", rd_en0, 0);
    chk("rst_wr_en", wr_en0, 0);
    chk("rst_pix_valid", vld0, 0);
    chk("rst_sol_eof", {sol0, eof0}, 0);
    chk("rst_rd_addr", rd_addr0, 0);
    chk("rst_wr_addr", wr_addr0, 0);
    chk("rst_pix", pix0, 0);
    chk("rst_wr_data", wr_data0, 0);
    chk("rst_busy_others", {busy1, busy2, vld1, vld2}, 0);
    rst = 1'b0; load = 1'b1;
    @(posedge clk); #1 load = 1'b0;

    // Frame with pix_ready held high: order, tags, latency, clear-behind
    b = acc0_q.size(); w = wr0_q.size(); d = done0_q.size();
    a = cyc; start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    chk("t1_busy_first", busy0, 1);
    chk("t1_rd_en_first", rd_en0, 1);
    chk("t1_rd_addr_first", rd_addr0, 0);
    for (int i = 0; i < 100 && done0_q.size() == d; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    chk("t1_done_count", done0_q.size() - d, 1);
    chk("t1_done_cycle", (done0_q.size() > d) ? done0_q[d] : -1, a + 18);
    chk("t1_first_valid_cycle", (acc0_cyc.size() > b) ? acc0_cyc[b] : -1, a + 3);
    chk("t1_beat_count", acc0_q.size() - b, 16);
    for (int i = 0; i < 16; i++) begin
      exp_beat = {4'(i), (i % 8) == 0, i == 15};
      got_beat = (acc0_q.size() > b + i) ? acc0_q[b + i] : 6'bx;
      chk($sformatf("t1_beat%0d", i), got_beat, exp_beat);
    end
    chk("t1_wr_count", wr0_q.size() - w, 16);
    for (int i = 0; i < 16; i++)
      chk($sformatf("t1_wr_addr%0d", i), (wr0_q.size() > w + i) ? wr0_q[w + i] : -1, i);
    orv = 4'h0;
    for (int i = 0; i < 16; i++) orv = orv | mem0[i];
    chk("t1_mem_cleared", orv, 0);
    chk("t1_busy_after", busy0, 0);

    // Reset in the middle of a frame
    load = 1'b1; @(posedge clk); #1 load = 1'b0;
    b = acc0_q.size();
    start0 = 1'b1; @(posedge clk); #1 start0 = 1'b0;
    for (int i = 0; i < 100 && acc0_q.size() - b < 5; i++) @(posedge clk);
    chk("rst_mid_reached_beat5", acc0_q.size() - b >= 5, 1);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("rst_mid_pix_valid", vld0, 0);
    chk("rst_mid_busy", busy0, 0);
    w = wr0_q.size(); b = acc0_q.size();
    repeat (10) @(posedge clk);
    #1;
    chk("rst_mid_no_writes", wr0_q.size() - w, 0);
    chk("rst_mid_no_beats", acc0_q.size() - b, 0);

    // Replay from pixel 0, with a second start mid-frame that must be ignored
    load = 1'b1; @(posedge clk); #1 load = 1'b0;
    b = acc0_q.size(); d = done0_q.size();
    start0 = 1'b1; @(posedge clk); #1 start0 = 1'b0;
    repeat (6) @(posedge clk);
    #1 start0 = 1'b1; @(posedge clk); #1 start0 = 1'b0;
    for (int i = 0; i < 100 && done0_q.size() == d; i++) @(posedge clk);
    repeat (30) @(posedge clk);
    #1;
    chk("replay_done_count", done0_q.size() - d, 1);
    chk("replay_beat_count", acc0_q.size() - b, 16);
    for (int i = 0; i < 16; i++) begin
      exp_beat = {4'(i), (i % 8) == 0, i == 15};
      got_beat = (acc0_q.size() > b + i) ? acc0_q[b + i] : 6'bx;
      chk($sformatf("replay_beat%0d", i), got_beat, exp_beat);
    end

    // RD_LAT=2 with random back-pressure
    b = acc1_q.size(); w = wr1_q.size(); d = done1_q.size();
    start1 = 1'b1; @(posedge clk); #1 start1 = 1'b0;
    for (int i = 0; i < 400 && done1_q.size() == d; i++) begin
      @(posedge clk);
      #1 rdy1 = 1'($urandom_range(0, 1));
    end
    rdy1 = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("t2_done_count", done1_q.size() - d, 1);
    chk("t2_beat_count", acc1_q.size() - b, 16);
    for (int i = 0; i < 16; i++) begin
      exp_beat = {4'(i), (i % 8) == 0, i == 15};
      got_beat = (acc1_q.size() > b + i) ? acc1_q[b + i] : 6'bx;
      chk($sformatf("t2_beat%0d", i), got_beat, exp_beat);
    end
    chk("t2_credit_limit", max_out1 <= 4, 1);
    chk("t2_hold_stable", unstable1, 0);
    chk("t2_wr_count", wr1_q.size() - w, 16);
    orv = 4'h0;
    for (int i = 0; i < 16; i++) orv = orv | mem1[i];
    chk("t2_mem_cleared", orv, 0);

    // Half-res: pixel pairs share a word, clear only after odd x
    b = acc2_q.size(); w = wr2_q.size(); d = done2_q.size(); r = rd2_q.size();
    start2 = 1'b1; @(posedge clk); #1 start2 = 1'b0;
    for (int i = 0; i < 100 && done2_q.size() == d; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    chk("t3_done_count", done2_q.size() - d, 1);
    chk("t3_rd_count", rd2_q.size() - r, 16);
    for (int i = 0; i < 16; i++)
      chk($sformatf("t3_rd_addr%0d", i), (rd2_q.size() > r + i) ? rd2_q[r + i] : -1, i / 2);
    chk("t3_wr_count", wr2_q.size() - w, 8);
    for (int k = 0; k < 8; k++)
      chk($sformatf("t3_wr_addr%0d", k), (wr2_q.size() > w + k) ? wr2_q[w + k] : -1, k);
    for (int i = 0; i < 16; i++) begin
      exp_beat = {4'(i / 2), (i % 8) == 0, i == 15};
      got_beat = (acc2_q.size() > b + i) ? acc2_q[b + i] : 6'bx;
      chk($sformatf("t3_beat%0d", i), got_beat, exp_beat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fb_scanout.md
# fb_scanout

Frame-buffer scanout reader: on a `start` pulse it walks the front frame buffer in raster order (x fastest, then y), issues one read per pixel to the frame-buffer read port, and delivers 4-bit colour indices as a ready/valid stream to the display/palette stage. It is the read-side counterpart of the sprite renderer, which writes the back buffer. Reads use a credit-limited pipeline with an internal FIFO, so downstream back-pressure never loses read data. An optional clear-behind write port restores each consumed location to the background index, leaving the buffer empty for the next render pass.

## Interface
- `H_RES`, 800, pixels per line
- `V_RES`, 480, lines per frame
- `PIXW`, 4, colour index width
- `ADDRW`, 19, frame-buffer address width
- `HALF_RES`, 0, 1 = address is `(x + y*H_RES) >> 1` (a pixel pair shares one word)
- `RD_LAT`, 1, frame-buffer read latency in cycles (1 or 2)
- `FIFO_DEPTH`, 4, output FIFO entries; must be a power of 2 and ≥ `RD_LAT+2`
- `CLEAR_EN`, 1, enable clear-behind writes
- `BG_INDEX`, 4'h0, value written by clear-behind
- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-high
- `start`  in  1  begin a frame; honoured only in IDLE
- `busy`  out  1  high from the cycle after `start` is accepted until `done`
- `done`  out  1  one-cycle pulse when the last pixel is accepted downstream
- `fb_rd_en`  out  1  read strobe
- `fb_rd_addr`  out  ADDRW  read address
- `fb_rd_data`  in  PIXW  read data, valid `RD_LAT` cycles after `fb_rd_en`
- `fb_wr_en`  out  1  clear-behind write strobe
- `fb_wr_addr`  out  ADDRW  clear-behind address
- `fb_wr_data`  out  PIXW  always `BG_INDEX`
- `pix`  out  PIXW  pixel colour index
- `pix_valid`  out  1  `pix` is valid
- `pix_ready`  in  1  downstream accepts the pixel
- `pix_sol`  out  1  `pix` is x = 0 (start of line)
- `pix_eof`  out  1  `pix` is the last pixel (x = H_RES-1, y = V_RES-1)

## Operation
- States:
  - IDLE: waits for `start`.
  - READ: issues reads.
  - DRAIN: all reads issued; waits for the FIFO to empty.
- Transitions:
  - IDLE→READ when `start` is high.
  - READ→DRAIN on the cycle the read for (H_RES-1, V_RES-1) issues.
  - DRAIN→IDLE when the `pix_eof` beat is accepted. `done` pulses on that same edge.
- Read issue: `fb_rd_en` is asserted in READ when `occupancy + inflight < FIFO_DEPTH`.
  - `inflight` is an `RD_LAT`-deep valid shift register.
  - `occupancy` is the FIFO count.
- Raster counters: x wraps at H_RES-1 to 0, and y then increments. The counters advance only on an issued read.
- Return path: each FIFO entry holds {data, sol, eof}. Data is captured from `fb_rd_data` when the shift-register tap is set. The sol/eof tags travel with the shift register.
- HALF_RES=1: the same address is read for x even and x+1, and each read produces its own entry.
- Clear-behind (CLEAR_EN=1):
  - `fb_wr_en` pulses with `fb_wr_addr` equal to the read address on the data-capture cycle.
  - With HALF_RES=1, it pulses only for odd x.
  - With CLEAR_EN=0, `fb_wr_en` stays 0.
- Boundary rules:
  - `start` while busy is ignored.
  - FIFO full: no reads issue; a push cannot be lost, because credit guarantees space.
  - Simultaneous push and pop keep the count unchanged.
  - Reset mid-frame: return to IDLE, flush the FIFO, clear `inflight`, and zero the counters. Data returning after reset is discarded, and no clear-behind writes occur.
- Reset values of outputs:
  - `busy`, `done`, `fb_rd_en`, `fb_wr_en`, `pix_valid`, `pix_sol`, `pix_eof` = 0.
  - `fb_rd_addr`, `fb_wr_addr`, `pix` = 0.
  - `fb_wr_data` = `BG_INDEX`.

## Timing
- `start` sampled at edge T. `busy` and the first `fb_rd_en` (address 0) are high in cycle T+1.
- Data is captured into the FIFO at edge T+1+RD_LAT, so the first `pix_valid` is high in cycle T+2+RD_LAT.
- With `pix_ready` held high, throughput is 1 pixel/cycle sustained. A full frame completes in H_RES·V_RES + RD_LAT + 2 cycles from `start`.
- `pix`, `pix_sol` and `pix_eof` are stable while `pix_valid` is high and `pix_ready` is low.
- Address arithmetic is `x + y*H_RES` computed at ADDRW bits; the maximum is 383999 at the defaults.

## Structure
- Shared package `fb_pkg` holds:
  - `H_RES`, `V_RES`, `FB_PIXELS`, `FB_ADDRW`.
  - `BG_INDEX`, `TRANSPARENT_INDEX` (4'hF).
  - A typedef `fb_beat_t` {pix, sol, eof}.
- One sub-module: `fb_fifo`, a synchronous FIFO of `fb_beat_t` with count output, `FIFO_DEPTH` entries, and first-word-fall-through.

## Test plan
- Frame of 8×2 (override H_RES=8, V_RES=2), buffer preloaded 0..15, `pix_ready`=1 → pixels 0..15 in order, `pix_sol` on beats 0 and 8, `pix_eof` on beat 15, `done` in cycle T+2+RD_LAT+15.
- Random `pix_ready` (50%), RD_LAT=2 → identical pixel sequence, no drop or duplicate; `occupancy+inflight` never exceeds 4.
- CLEAR_EN=1, BG_INDEX=0 → after `done`, all 16 buffer words read back 0; exactly 16 `fb_wr_en` pulses, addresses 0..15.
- HALF_RES=1, 8×2 → read addresses 0,0,1,1,…,7,7; clear writes only on odd x (8 pulses).
- `rst` asserted at beat 5 → the next cycle shows `pix_valid`=0 and `busy`=0; no further writes. A new `start` replays from pixel 0.
- `start` pulsed again mid-frame → ignored; exactly one `done` per frame.
